// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - direction codes and tracker state shared by the maze blocks
package maze_pkg;

   localparam logic [3:0] DIR_NONE  = 4'd0;
   localparam logic [3:0] DIR_UP    = 4'd1;
   localparam logic [3:0] DIR_DOWN  = 4'd2;
   localparam logic [3:0] DIR_LEFT  = 4'd4;
   localparam logic [3:0] DIR_RIGHT = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_CHECK,
      ST_DONE
   } tracker_state_t;

endpackage

// File: rtl/maze_step_calc.sv
// rtl/maze_step_calc.sv - maps (position, direction) to target cell, bounds check and request validity
module maze_step_calc
   import maze_pkg::*;
#(
   parameter int GRID_W = 16,
   parameter int GRID_H = 12,
   parameter int X_W    = $clog2(GRID_W),
   parameter int Y_W    = $clog2(GRID_H)
) (
   input  logic [X_W-1:0] pos_x,
   input  logic [Y_W-1:0] pos_y,
   input  logic [3:0]     direction,
   output logic [X_W-1:0] nx,
   output logic [Y_W-1:0] ny,
   output logic           in_bounds,
   output logic           valid
);

   // Target may wrap when out of bounds; in_bounds tells the caller to ignore it.
   always_comb begin
      nx        = pos_x;
      ny        = pos_y;
      in_bounds = 1'b0;
      valid     = 1'b1;
      case (direction)
         DIR_UP: begin
            ny        = pos_y - 1'b1;
            in_bounds = (pos_y != '0);
         end
         DIR_DOWN: begin
            ny        = pos_y + 1'b1;
            in_bounds = (pos_y != Y_W'(GRID_H - 1));
         end
         DIR_LEFT: begin
            nx        = pos_x - 1'b1;
            in_bounds = (pos_x != '0);
         end
         DIR_RIGHT: begin
            nx        = pos_x + 1'b1;
            in_bounds = (pos_x != X_W'(GRID_W - 1));
         end
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/maze_position_tracker.sv
// rtl/maze_position_tracker.sv - player position tracker with wall-map lookup, move counter and goal flag
module maze_position_tracker
   import maze_pkg::*;
#(
   parameter int GRID_W  = 16,
   parameter int GRID_H  = 12,
   parameter int START_X = 0,
   parameter int START_Y = 0,
   parameter int GOAL_X  = 15,
   parameter int GOAL_Y  = 11,
   parameter int CNT_W   = 10,
   parameter int ADDR_W  = $clog2(GRID_W * GRID_H),
   parameter int X_W     = $clog2(GRID_W),
   parameter int Y_W     = $clog2(GRID_H)
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [3:0]        direction,
   input  logic              starting_pos,
   output logic [ADDR_W-1:0] wall_addr,
   output logic              wall_rd,
   input  logic              wall_rdata,
   output logic [X_W-1:0]    pos_x,
   output logic [Y_W-1:0]    pos_y,
   output logic [CNT_W-1:0]  move_count,
   output logic              moved,
   output logic              blocked,
   output logic              at_goal,
   output logic              busy
);

   localparam logic [X_W-1:0] START_XV    = X_W'(START_X);
   localparam logic [Y_W-1:0] START_YV    = Y_W'(START_Y);
   localparam logic [X_W-1:0] GOAL_XV     = X_W'(GOAL_X);
   localparam logic [Y_W-1:0] GOAL_YV     = Y_W'(GOAL_Y);
   localparam logic           AT_GOAL_RST = (START_X == GOAL_X) && (START_Y == GOAL_Y);

   tracker_state_t    state, state_next;
   logic [X_W-1:0]    nx_q, nx_next, step_nx, pos_x_next;
   logic [Y_W-1:0]    ny_q, ny_next, step_ny, pos_y_next;
   logic [CNT_W-1:0]  count_next;
   logic [ADDR_W-1:0] wall_addr_next;
   logic              step_in_bounds, step_valid;
   logic              wall_rd_next, moved_next, blocked_next, at_goal_next, busy_next;

   maze_step_calc #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H),
      .X_W    (X_W),
      .Y_W    (Y_W)
   ) u_step_calc (
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .direction (direction),
      .nx        (step_nx),
      .ny        (step_ny),
      .in_bounds (step_in_bounds),
      .valid     (step_valid)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= ST_IDLE;
         pos_x      <= START_XV;
         pos_y      <= START_YV;
         nx_q       <= START_XV;
         ny_q       <= START_YV;
         move_count <= '0;
         wall_addr  <= '0;
         wall_rd    <= 1'b0;
         moved      <= 1'b0;
         blocked    <= 1'b0;
         at_goal    <= AT_GOAL_RST;
         busy       <= 1'b0;
      end else begin
         state      <= state_next;
         pos_x      <= pos_x_next;
         pos_y      <= pos_y_next;
         nx_q       <= nx_next;
         ny_q       <= ny_next;
         move_count <= count_next;
         wall_addr  <= wall_addr_next;
         wall_rd    <= wall_rd_next;
         moved      <= moved_next;
         blocked    <= blocked_next;
         at_goal    <= at_goal_next;
         busy       <= busy_next;
      end
   end

   // Outputs are computed one state ahead so that every pulse is a flop output.
   always_comb begin
      state_next     = state;
      pos_x_next     = pos_x;
      pos_y_next     = pos_y;
      nx_next        = nx_q;
      ny_next        = ny_q;
      count_next     = move_count;
      wall_addr_next = wall_addr;
      wall_rd_next   = 1'b0;
      moved_next     = 1'b0;
      blocked_next   = 1'b0;
      if (starting_pos) begin
         state_next = ST_IDLE;
         pos_x_next = START_XV;
         pos_y_next = START_YV;
         count_next = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (step_valid && !at_goal) begin
                  if (step_in_bounds) begin
                     nx_next        = step_nx;
                     ny_next        = step_ny;
                     wall_rd_next   = 1'b1;
                     wall_addr_next = ADDR_W'(step_ny) * ADDR_W'(GRID_W) + ADDR_W'(step_nx);
                     state_next     = ST_LOOKUP;
                  end else begin
                     blocked_next = 1'b1;
                     state_next   = ST_DONE;
                  end
               end
            end
            ST_LOOKUP: state_next = ST_CHECK;
            ST_CHECK: begin
               if (!wall_rdata) begin
                  pos_x_next = nx_q;
                  pos_y_next = ny_q;
                  count_next = (move_count == {CNT_W{1'b1}}) ? move_count : move_count + 1'b1;
                  moved_next = 1'b1;
               end else begin
                  blocked_next = 1'b1;
               end
               state_next = ST_DONE;
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
         endcase
      end
      at_goal_next = (pos_x_next == GOAL_XV) && (pos_y_next == GOAL_YV);
      busy_next    = (state_next != ST_IDLE);
   end

endmodule
